// File: rtl/emern_spi_cmd_tx_if.sv
// rtl/emern_spi_cmd_tx_if.sv - command frame handshake bundle for emern_spi_cmd_tx
//
// Purpose: carries one 56-bit command frame from a source to the SPI transmitter.
// Signals:
//   cmd_valid  source offers a frame
//   cmd_ready  transmitter idle; transfer happens on a clock edge with valid & ready
//   cmd_data   [7:0] command byte, [55:8] payload; bit 0 is sent first
// Modports:
//   master  frame source (drives valid/data, observes ready)
//   slave   transmitter (observes valid/data, drives ready)

interface emern_spi_cmd_tx_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [55:0] cmd_data;

   modport master (
      output cmd_valid,
      output cmd_data,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_data,
      output cmd_ready
   );
endinterface

// File: rtl/emern_spi_cmd_tx.sv
// rtl/emern_spi_cmd_tx.sv - host-side SPI mode-0 command frame transmitter
//
// Purpose: takes one 56-bit command frame per handshake and shifts it out
// LSB-first on CS/SCK/MOSI, with an optional MISO capture return path.
//
// Optional feature macro: SPI_TX_MISO_EN
//   defined   - miso_in is synchronised, sampled on the last clk of every SCK-high
//               phase, and the captured frame is published on rx_data at done
//   undefined - miso_in is ignored and rx_data is constant 0
//
// Parameters:
//   CLK_DIV  SCK half-period in clk cycles (4..255)
//   CS_GAP   clk cycles CS is held high after a frame before accepting another (1..255)
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   cmd       slave side of the command handshake (valid/ready/data)
//   tx_en     transmit window; an SCK rising edge is only issued while high
//   busy      frame in flight (CS low or CS gap)
//   done      one-cycle pulse when CS returns high after a complete frame
//   cs_out    chip select, active low
//   sck_out   SPI clock, idle low
//   mosi_out  serial data to the GPU
//   miso_in   serial data from the GPU
//   rx_data   captured MISO frame, bit i = i-th bit received

module emern_spi_cmd_tx #(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   emern_spi_cmd_tx_if.slave     cmd,
   input  logic                  tx_en,
   output logic                  busy,
   output logic                  done,
   output logic                  cs_out,
   output logic                  sck_out,
   output logic                  mosi_out,
   input  logic                  miso_in,
   output logic [55:0]           rx_data
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
   localparam logic [5:0] BIT_LAST = 6'd55;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOW   = 3'd1,
      S_HIGH  = 3'd2,
      S_TRAIL = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t      state;
   logic [7:0]  phase;
   logic [5:0]  bit_idx;
   logic [55:0] shreg;
   logic        ready_q;

   assign cmd.cmd_ready = ready_q;

   // Every output is a flop written alongside the state so nothing glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         phase    <= 8'd0;
         bit_idx  <= 6'd0;
         shreg    <= 56'd0;
         ready_q  <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         cs_out   <= 1'b1;
         sck_out  <= 1'b0;
         mosi_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd.cmd_valid) begin
                  shreg    <= cmd.cmd_data;
                  bit_idx  <= 6'd0;
                  phase    <= 8'd0;
                  mosi_out <= cmd.cmd_data[0];
                  cs_out   <= 1'b0;
                  ready_q  <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_LOW;
               end
            end

            S_LOW: begin
               // Once the minimum low time has elapsed the counter parks at its
               // last value, so a tx_en stall releases SCK on the next edge.
               if (phase == DIV_LAST) begin
                  if (tx_en) begin
                     phase   <= 8'd0;
                     sck_out <= 1'b1;
                     state   <= S_HIGH;
                  end
               end else begin
                  phase <= phase + 8'd1;
               end
            end

            S_HIGH: begin
               if (phase == DIV_LAST) begin
                  phase   <= 8'd0;
                  sck_out <= 1'b0;
                  if (bit_idx == BIT_LAST) begin
                     state <= S_TRAIL;
                  end else begin
                     bit_idx  <= bit_idx + 6'd1;
                     mosi_out <= shreg[1];
                     shreg    <= {1'b0, shreg[55:1]};
                     state    <= S_LOW;
                  end
               end else begin
                  phase <= phase + 8'd1;
               end
            end

            S_TRAIL: begin
               // CS held low one more half-period so the receiver's input
               // synchronisers and completion register see the last bit.
               if (phase == DIV_LAST) begin
                  phase    <= 8'd0;
                  cs_out   <= 1'b1;
                  mosi_out <= 1'b0;
                  done     <= 1'b1;
                  state    <= S_GAP;
               end else begin
                  phase <= phase + 8'd1;
               end
            end

            S_GAP: begin
               if (phase == GAP_LAST) begin
                  phase   <= 8'd0;
                  ready_q <= 1'b1;
                  busy    <= 1'b0;
                  state   <= S_IDLE;
               end else begin
                  phase <= phase + 8'd1;
               end
            end

            default: begin
               state    <= S_IDLE;
               phase    <= 8'd0;
               ready_q  <= 1'b1;
               busy     <= 1'b0;
               cs_out   <= 1'b1;
               sck_out  <= 1'b0;
               mosi_out <= 1'b0;
            end
         endcase
      end
   end

`ifdef SPI_TX_MISO_EN
   logic        miso_s1;
   logic        miso_s2;
   logic [55:0] rx_shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         miso_s1  <= 1'b0;
         miso_s2  <= 1'b0;
         rx_shreg <= 56'd0;
         rx_data  <= 56'd0;
      end else begin
         miso_s1 <= miso_in;
         miso_s2 <= miso_s1;
         // Last clk of the SCK-high phase: the GPU drove this bit on the
         // preceding falling edge, well past the two-flop delay.
         if (state == S_HIGH && phase == DIV_LAST) begin
            rx_shreg[bit_idx] <= miso_s2;
         end
         // Same edge that raises done, so rx_data is valid alongside it.
         if (state == S_TRAIL && phase == DIV_LAST) begin
            rx_data <= rx_shreg;
         end
      end
   end
`else
   logic unused_miso;
   assign unused_miso = miso_in;
   assign rx_data     = 56'd0;
`endif

endmodule
